// File: rtl/vending_pkg.sv
// Shared vending-machine definitions: coin line indices/values and collector FSM states.
// Coin encoding is common to the collector inputs and the change dispenser outputs.
package vending_pkg;

  localparam int COIN5  = 0;
  localparam int COIN10 = 1;
  localparam int COIN20 = 2;
  localparam int COIN50 = 3;

  localparam logic [6:0] VAL5  = 7'd5;
  localparam logic [6:0] VAL10 = 7'd10;
  localparam logic [6:0] VAL20 = 7'd20;
  localparam logic [6:0] VAL50 = 7'd50;

  typedef logic [1:0] state_t;
  localparam state_t IDLE    = 2'd0;
  localparam state_t COLLECT = 2'd1;
  localparam state_t START   = 2'd2;
  localparam state_t WAIT    = 2'd3;

  // Value of all coin strobes seen in one cycle (at most 85).
  function automatic logic [6:0] coin_sum(input logic [3:0] strobes);
    coin_sum = (strobes[COIN5]  ? VAL5  : 7'd0)
             + (strobes[COIN10] ? VAL10 : 7'd0)
             + (strobes[COIN20] ? VAL20 : 7'd0)
             + (strobes[COIN50] ? VAL50 : 7'd0);
  endfunction

endpackage

// File: rtl/coin_debounce.sv
// One coin line: 2-FF synchronizer, saturating low-sample counter, single strobe per insertion.
// Strobe appears 2+DEBOUNCE_CYCLES cycles after the pin first goes low.
module coin_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic pin_n,
  output logic strobe
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES);

  logic sync1;
  logic sync2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1  <= 1'b1;
      sync2  <= 1'b1;
      cnt    <= '0;
      strobe <= 1'b0;
    end else begin
      sync1  <= pin_n;
      sync2  <= sync1;
      strobe <= 1'b0;
      // Counter parks at CMAX until the line goes high, so one insertion gives one strobe.
      if (sync2) begin
        cnt <= '0;
      end else if (cnt != CMAX) begin
        cnt    <= cnt + 1'b1;
        strobe <= (cnt == CMAX - 1'b1);
      end
    end
  end

endmodule

// File: rtl/coin_collector.sv
// Vending front end: debounces four coin lines, accumulates the total, hands it to the dispenser.
// Optional idle auto-cancel in COLLECT is enabled by defining COIN_COLLECTOR_TIMEOUT_EN.
module coin_collector
  import vending_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int PRICE           = 25,
  parameter int MONEY_MAX       = 255,
  parameter int TIMEOUT_CYCLES  = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] coin_n,
  input  logic       buy,
  input  logic       cancel,
  input  logic       change_busy,
  output logic [7:0] money,
  output logic       change_en,
  output logic       move25,
  output logic       enough,
  output logic       reject
);

  localparam logic [7:0] PRICE_W = 8'(PRICE);
  localparam logic [8:0] MAX_W   = 9'(MONEY_MAX);

  logic [3:0] strobe;
  state_t     state;
  logic [6:0] sum;
  logic [8:0] total;
  logic       has_coin;
  logic       fits;
  logic       accept_state;
  logic       busy_seen;
  logic [1:0] wait_cnt;
  logic       go_start;
  logic       go_buy;
  logic       timeout;

  for (genvar i = 0; i < 4; i++) begin : g_deb
    coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clk    (clk),
      .rst    (rst),
      .pin_n  (coin_n[i]),
      .strobe (strobe[i])
    );
  end

  assign sum          = coin_sum(strobe);
  assign total        = {1'b0, money} + {2'b0, sum};
  assign has_coin     = |strobe;
  assign fits         = (total <= MAX_W);
  assign accept_state = (state == IDLE) || (state == COLLECT);
  assign change_en    = (state == START);
  assign enough       = (state == COLLECT) && (money >= PRICE_W);

`ifdef COIN_COLLECTOR_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] idle_cnt;
  logic          activity;

  assign activity = has_coin || buy || cancel;
  assign timeout  = (state == COLLECT) && !activity && (idle_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst || state != COLLECT || activity) idle_cnt <= '0;
    else                                     idle_cnt <= idle_cnt + 1'b1;
  end
`else
  logic unused_timeout;
  assign timeout        = 1'b0;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  // Cancel has priority over buy; a timeout behaves as a cancel.
  always_comb begin
    go_start = 1'b0;
    go_buy   = 1'b0;
    if (state == COLLECT) begin
      if (cancel || timeout) begin
        go_start = 1'b1;
      end else if (buy && money >= PRICE_W) begin
        go_start = 1'b1;
        go_buy   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      money     <= 8'd0;
      move25    <= 1'b0;
      reject    <= 1'b0;
      busy_seen <= 1'b0;
      wait_cnt  <= 2'd0;
    end else begin
      reject <= has_coin && (!accept_state || !fits);
      case (state)
        IDLE: begin
          if (has_coin && fits) begin
            money <= total[7:0];
            state <= COLLECT;
          end
        end
        COLLECT: begin
          if (has_coin && fits) money <= total[7:0];
          if (go_start) begin
            state  <= START;
            move25 <= go_buy;
          end
        end
        START: begin
          state     <= WAIT;
          busy_seen <= 1'b0;
          wait_cnt  <= 2'd0;
        end
        WAIT: begin
          if (change_busy) busy_seen <= 1'b1;
          // Leave on busy's falling edge, or when busy never rose within the window.
          if (!change_busy && (busy_seen || wait_cnt == 2'd3)) begin
            state  <= IDLE;
            money  <= 8'd0;
            move25 <= 1'b0;
          end else if (wait_cnt != 2'd3) begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_coin_collector.sv
// Directed bench for coin_collector: debounce timing, accumulation, purchase/refund handshakes,
// saturation and reject behaviour; auto-cancel timing when COIN_COLLECTOR_TIMEOUT_EN is defined.
module tb_coin_collector;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] coin_n = 4'hF;
  logic       buy = 1'b0;
  logic       cancel = 1'b0;
  logic       change_busy = 1'b0;
  logic [7:0] money;
  logic       change_en;
  logic       move25;
  logic       enough;
  logic       reject;

  int errors = 0;
  int checks = 0;

  coin_collector #(
    .DEBOUNCE_CYCLES (4),
    .PRICE           (25),
    .MONEY_MAX       (255),
    .TIMEOUT_CYCLES  (50)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .coin_n      (coin_n),
    .buy         (buy),
    .cancel      (cancel),
    .change_busy (change_busy),
    .money       (money),
    .change_en   (change_en),
    .move25      (move25),
    .enough      (enough),
    .reject      (reject)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=no finish expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Hold the masked lines low for 8 cycles, then high for 4; count reject pulses seen.
  task automatic insert(input logic [3:0] mask, output int rej);
    rej = 0;
    coin_n = ~mask;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (reject) rej++;
      if (i == 7) coin_n = 4'hF;
    end
  endtask

  task automatic wait_change(output int got, output logic m25, output logic [7:0] mny);
    got = 0;
    m25 = 1'b0;
    mny = 8'd0;
    for (int i = 0; i < 20 && got == 0; i++) begin
      if (change_en) begin
        got = 1;
        m25 = move25;
        mny = money;
      end else begin
        @(negedge clk);
      end
    end
  endtask

  task automatic wait_idle(output int ok);
    ok = 0;
    for (int i = 0; i < 40 && ok == 0; i++) begin
      if (dut.state == 2'd0) ok = 1;
      else @(negedge clk);
    end
  endtask

  initial begin
    int rej;
    int got;
    int ok;
    int cnt;
    logic m25;
    logic [7:0] mny;

    // Reset
    rst = 1'b1;
    tick(3);
    check("rst_money", money, 0);
    check("rst_change_en", change_en, 0);
    check("rst_move25", move25, 0);
    check("rst_enough", enough, 0);
    check("rst_reject", reject, 0);
    check("rst_state", dut.state, 0);

    // 10 coin held low 10 cycles: money appears on the 7th edge after the first low sample
    rst = 1'b0;
    coin_n = 4'b1101;
    tick(6);
    check("deb_before_strobe", money, 0);
    tick(1);
    check("deb_after_strobe", money, 10);
    tick(3);
    coin_n = 4'hF;
    tick(4);
    check("coin10_money", money, 10);
    check("coin10_state", dut.state, 1);
    check("coin10_enough", enough, 0);

    // 3-cycle glitch adds nothing
    coin_n = 4'b1101;
    tick(3);
    coin_n = 4'hF;
    tick(8);
    check("glitch_money", money, 10);

    // Refund with no dispenser activity: window expires back to IDLE
    cancel = 1'b1;
    tick(1);
    cancel = 1'b0;
    wait_change(got, m25, mny);
    check("cancel_change_en", got, 1);
    check("cancel_move25", m25, 0);
    check("cancel_money", mny, 10);
    tick(1);
    check("change_en_one_cycle", change_en, 0);
    wait_idle(ok);
    check("cancel_idle", ok, 1);
    check("cancel_cleared", money, 0);

    // 20 + 10, then purchase with a 3-cycle busy pulse
    insert(4'b0100, rej);
    insert(4'b0010, rej);
    check("buy_money", money, 30);
    check("buy_enough", enough, 1);
    buy = 1'b1;
    tick(1);
    buy = 1'b0;
    wait_change(got, m25, mny);
    check("buy_change_en", got, 1);
    check("buy_move25", m25, 1);
    check("buy_money_at_en", mny, 30);
    tick(1);
    change_busy = 1'b1;
    tick(3);
    check("buy_move25_held", move25, 1);
    check("buy_money_frozen", money, 30);
    change_busy = 1'b0;
    tick(1);
    check("buy_done_state", dut.state, 0);
    check("buy_done_money", money, 0);
    check("buy_done_move25", move25, 0);

    // 50, buy and cancel together: cancel wins; coin during WAIT is rejected
    insert(4'b1000, rej);
    check("fifty_money", money, 50);
    buy = 1'b1;
    cancel = 1'b1;
    tick(1);
    buy = 1'b0;
    cancel = 1'b0;
    wait_change(got, m25, mny);
    check("both_change_en", got, 1);
    check("both_move25", m25, 0);
    check("both_money", mny, 50);
    tick(1);
    change_busy = 1'b1;
    insert(4'b0010, rej);
    check("wait_reject_count", rej, 1);
    check("wait_money", money, 50);
    check("wait_state", dut.state, 3);
    change_busy = 1'b0;
    tick(2);
    check("wait_done_state", dut.state, 0);
    check("wait_done_money", money, 0);

    // buy below price is ignored
    insert(4'b0100, rej);
    check("low_money", money, 20);
    buy = 1'b1;
    tick(1);
    buy = 1'b0;
    wait_change(got, m25, mny);
    check("low_no_change_en", got, 0);
    check("low_state", dut.state, 1);
    check("low_money_kept", money, 20);
    cancel = 1'b1;
    tick(1);
    cancel = 1'b0;
    wait_idle(ok);
    check("low_cleanup_idle", ok, 1);

    // Simultaneous 50+5, then fill to 240 and overflow with a 20
    insert(4'b1001, rej);
    check("multi_money", money, 55);
    check("multi_no_reject", rej, 0);
    insert(4'b1000, rej);
    insert(4'b1000, rej);
    insert(4'b1000, rej);
    insert(4'b0111, rej);
    check("fill_money", money, 240);
    insert(4'b0100, rej);
    check("sat_reject_count", rej, 1);
    check("sat_money", money, 240);
    check("sat_state", dut.state, 1);

`ifdef COIN_COLLECTOR_TIMEOUT_EN
    cancel = 1'b1;
    tick(1);
    cancel = 1'b0;
    wait_idle(ok);
    insert(4'b0010, rej);
    cnt = 5;
    while (!change_en && cnt < 100) begin
      tick(1);
      cnt++;
    end
    check("timeout_cycles", cnt, 50);
    check("timeout_move25", move25, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
